// File: rtl/turn_queue.sv
//==============================================================================
// Module   : turn_queue
// Purpose  : Per-player queue of pending snake turns. Button clicks are
//            edge-detected and queued; each game step pops at most one turn
//            per channel and rotates that channel's heading.
// Config   : TURN_QUEUE_OVERWRITE_EN - when defined, a push into a full
//            queue replaces the newest entry instead of being dropped.
// Encoding : mode  : 0 MENU, 1 GAME, 2 PAUSE, 3 OVER
//            dir   : 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT (2 bits per channel)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module turn_queue #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic [1:0]                        mode,
  input  logic [N_CH-1:0]                   left,
  input  logic [N_CH-1:0]                   right,
  output logic [2*N_CH-1:0]                 dir,
  output logic [N_CH*$clog2(DEPTH+1)-1:0]   pending,
  output logic [N_CH-1:0]                   ovf,
  output logic [N_CH-1:0]                   turned
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = $clog2(DEPTH);
  localparam logic [1:0]      GAME     = 2'd1;
  localparam logic [1:0]      D_UP     = 2'd0;
  localparam logic [1:0]      D_RIGHT  = 2'd1;
  localparam logic [1:0]      D_DOWN   = 2'd2;
  localparam logic [1:0]      D_LEFT   = 2'd3;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  // Heading after one turn; an unknown encoding falls back to UP.
  function automatic logic [1:0] f_turn(input logic [1:0] d, input logic is_r);
    logic [1:0] n;
    case (d)
      D_UP:    n = is_r ? D_RIGHT : D_LEFT;
      D_RIGHT: n = is_r ? D_DOWN  : D_UP;
      D_DOWN:  n = is_r ? D_LEFT  : D_RIGHT;
      D_LEFT:  n = is_r ? D_UP    : D_DOWN;
      default: n = D_UP;
    endcase
    return n;
  endfunction

  logic tick_q;
  logic w_step;
  logic w_active;

  assign w_step   = tick & ~tick_q;
  assign w_active = (mode == GAME);

  // Shared game-step edge history.
  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          left_q, right_q;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dir_q, dir_d;
    logic          ovf_q, ovf_d;
    logic          turned_q, turned_d;
    logic          mem_q [DEPTH];
    logic          w_click_l, w_click_r, w_push, w_pop, w_full, w_push_acc;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_addr;

    assign w_click_l = left[i]  & ~left_q;
    assign w_click_r = right[i] & ~right_q;
    // Both buttons clicked together is ambiguous, so it is dropped entirely.
    assign w_push    = w_active & (w_click_l ^ w_click_r);
    assign w_pop     = w_active & w_step & (cnt_q != '0);
    assign w_full    = (cnt_q == FULL_CNT);

    // Queue bookkeeping and heading update for this channel.
    always_comb begin
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      ovf_d      = ovf_q;
      turned_d   = w_pop;
      w_push_acc = 1'b0;
      w_wr_en    = 1'b0;
      w_wr_addr  = wptr_q;

      // The pop reads the entry stored before this edge, so a click arriving
      // with the step is queued and never applied in the same cycle.
      if (w_pop) begin
        rptr_d = rptr_q + PTR_ONE;
        dir_d  = f_turn(dir_q, mem_q[rptr_q]);
      end

      if (w_push) begin
        if (!w_full || w_pop) begin
          w_push_acc = 1'b1;
          w_wr_en    = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
        end else begin
          ovf_d = 1'b1;
`ifdef TURN_QUEUE_OVERWRITE_EN
          w_wr_en   = 1'b1;
          w_wr_addr = wptr_q - PTR_ONE;
`endif
        end
      end

      if (w_push_acc && !w_pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!w_push_acc && w_pop) cnt_d = cnt_q - CNT_ONE;

      // Outside GAME the channel idles and the queue restarts empty.
      if (!w_active) begin
        rptr_d   = '0;
        wptr_d   = '0;
        cnt_d    = '0;
        dir_d    = D_UP;
        ovf_d    = 1'b0;
        turned_d = 1'b0;
        w_wr_en  = 1'b0;
      end
    end

    // Channel state registers and button edge history.
    always_ff @(posedge clk) begin
      if (rst) begin
        left_q   <= 1'b0;
        right_q  <= 1'b0;
        rptr_q   <= '0;
        wptr_q   <= '0;
        cnt_q    <= '0;
        dir_q    <= D_UP;
        ovf_q    <= 1'b0;
        turned_q <= 1'b0;
      end else begin
        left_q   <= left[i];
        right_q  <= right[i];
        rptr_q   <= rptr_d;
        wptr_q   <= wptr_d;
        cnt_q    <= cnt_d;
        dir_q    <= dir_d;
        ovf_q    <= ovf_d;
        turned_q <= turned_d;
      end
    end

    // Turn storage: 1 = right turn, 0 = left turn; contents are don't-care
    // while empty, so no reset is needed.
    always_ff @(posedge clk) begin
      if (w_wr_en && !rst) mem_q[w_wr_addr] <= w_click_r;
    end

    assign dir[2*i +: 2]      = w_active ? dir_q : D_UP;
    assign pending[i*CW +: CW] = w_active ? cnt_q : '0;
    assign ovf[i]             = w_active & ovf_q;
    assign turned[i]          = w_active & turned_q;
  end

endmodule

`default_nettype wire
